// File: rtl/bp_fe_cmd_arbiter.sv
// bp_fe_cmd_arbiter
// Arbitrates between a single-entry redirect slot and a small attaboy FIFO,
// presenting one command at a time to the front end with valid-then-yumi.
// Redirects strictly win at every decision point, an offered command is never
// preempted, attaboys are never back-pressured (they are dropped and counted
// when the FIFO is full), and flush discards queued attaboys while keeping an
// attaboy that is already on the output.
module bp_fe_cmd_arbiter #(
  parameter int cmd_width_p   = 128,
  parameter int attaboy_els_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic [cmd_width_p-1:0] redirect_cmd_i,
  input  logic                   redirect_v_i,
  output logic                   redirect_ready_o,

  input  logic [cmd_width_p-1:0] attaboy_cmd_i,
  input  logic                   attaboy_v_i,
  input  logic                   flush_i,

  output logic [cmd_width_p-1:0] fe_cmd_o,
  output logic                   fe_cmd_v_o,
  input  logic                   fe_cmd_yumi_i,

  output logic [7:0]             drop_count_o
);

  localparam int ptr_w_lp = (attaboy_els_p > 1) ? $clog2(attaboy_els_p) : 1;
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(attaboy_els_p);

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_redir = 2'd1,
    e_atta  = 2'd2
  } state_e;

  state_e                 state_r, state_n;

  logic                   redirect_full_r, redirect_full_n;
  logic [cmd_width_p-1:0] redirect_r;

  logic [cmd_width_p-1:0] mem_r [attaboy_els_p];
  logic [ptr_w_lp-1:0]    head_r, head_n;
  logic [ptr_w_lp-1:0]    tail_r, tail_n;
  logic [cnt_w_lp-1:0]    count_r, count_n;

  logic [7:0]             drop_r, drop_n;

  logic                   redir_deq, atta_deq;
  logic                   redir_enq, atta_enq, atta_drop;
  logic                   fifo_full, decide, hold_head;

  // Saturating 8-bit increment for the overflow drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  // Single-step modular pointer advance; depth is a power of two so the
  // natural wrap of the pointer width gives the modulo.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p,
                                                  input logic                en);
    return p + ptr_w_lp'(en);
  endfunction

  // Handshake decode: what is consumed, captured or dropped this cycle.
  always_comb begin
    redir_deq        = (state_r == e_redir) & fe_cmd_yumi_i;
    atta_deq         = (state_r == e_atta)  & fe_cmd_yumi_i;
    redirect_ready_o = reset_i | ~redirect_full_r | redir_deq;
    redir_enq        = redirect_v_i & redirect_ready_o;
    fifo_full        = (count_r == els_lp);
    // Flush takes precedence over an incoming attaboy; that attaboy is
    // discarded silently rather than counted as an overflow drop.
    atta_enq         = attaboy_v_i & ~flush_i & (~fifo_full | atta_deq);
    atta_drop        = attaboy_v_i & ~flush_i &  fifo_full & ~atta_deq;
    // A new choice is made only when nothing is on offer or the offer is taken.
    decide           = (state_r == e_idle) | fe_cmd_yumi_i;
    // An attaboy already shown to the FE must survive a flush until consumed.
    hold_head        = (state_r == e_atta) & ~fe_cmd_yumi_i;
  end

  // Next-state contents of the redirect slot, FIFO control and arbiter state.
  always_comb begin
    redirect_full_n = redir_enq | (redirect_full_r & ~redir_deq);

    head_n  = ptr_inc(head_r, atta_deq);
    tail_n  = tail_r;
    count_n = count_r;
    if (flush_i) begin
      if (hold_head) begin
        tail_n  = ptr_inc(head_r, 1'b1);
        count_n = cnt_w_lp'(1);
      end else begin
        tail_n  = head_n;
        count_n = '0;
      end
    end else begin
      tail_n  = ptr_inc(tail_r, atta_enq);
      count_n = count_r + cnt_w_lp'(atta_enq) - cnt_w_lp'(atta_deq);
    end

    drop_n = atta_drop ? sat_inc8(drop_r) : drop_r;

    state_n = state_r;
    if (decide) begin
      if (redirect_full_n) begin
        state_n = e_redir;
      end else if (count_n != '0) begin
        state_n = e_atta;
      end else begin
        state_n = e_idle;
      end
    end
  end

  // Control registers: state, occupancy, pointers and drop counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r         <= e_idle;
      redirect_full_r <= 1'b0;
      head_r          <= '0;
      tail_r          <= '0;
      count_r         <= '0;
      drop_r          <= '0;
    end else begin
      state_r         <= state_n;
      redirect_full_r <= redirect_full_n;
      head_r          <= head_n;
      tail_r          <= tail_n;
      count_r         <= count_n;
      drop_r          <= drop_n;
    end
  end

  // Command storage: written only on accepted pushes, never reset.
  always_ff @(posedge clk_i) begin
    if (redir_enq & ~reset_i) begin
      redirect_r <= redirect_cmd_i;
    end
    if (atta_enq & ~reset_i) begin
      mem_r[tail_r] <= attaboy_cmd_i;
    end
  end

  // Output selection follows the registered state; idle drives zero.
  always_comb begin
    case (state_r)
      e_redir: fe_cmd_o = redirect_r;
      e_atta:  fe_cmd_o = mem_r[head_r];
      default: fe_cmd_o = '0;
    endcase
    fe_cmd_v_o   = ~reset_i & (state_r != e_idle);
    drop_count_o = drop_r;
  end

endmodule

// File: tb/tb_bp_fe_cmd_arbiter.sv
// Testbench for bp_fe_cmd_arbiter: directed scenarios plus a randomized run
// against a queue-based behavioural model of the arbitration rules.
module tb_bp_fe_cmd_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_i, redirect_v_i, attaboy_v_i, flush_i, fe_cmd_yumi_i;
  logic [W-1:0] redirect_cmd_i, attaboy_cmd_i, fe_cmd_o;
  logic         redirect_ready_o, fe_cmd_v_o;
  logic [7:0]   drop_count_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model: offered = 0 none, 1 redirect, 2 attaboy head.
  logic [W-1:0] m_q[$];
  bit           m_rv;
  logic [W-1:0] m_rcmd;
  int           m_off;
  int           m_drop;

  always #5 clk = ~clk;

  bp_fe_cmd_arbiter #(.cmd_width_p(W), .attaboy_els_p(N)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .redirect_cmd_i  (redirect_cmd_i),
    .redirect_v_i    (redirect_v_i),
    .redirect_ready_o(redirect_ready_o),
    .attaboy_cmd_i   (attaboy_cmd_i),
    .attaboy_v_i     (attaboy_v_i),
    .flush_i         (flush_i),
    .fe_cmd_o        (fe_cmd_o),
    .fe_cmd_v_o      (fe_cmd_v_o),
    .fe_cmd_yumi_i   (fe_cmd_yumi_i),
    .drop_count_o    (drop_count_o)
  );

  function automatic bit m_v();
    return !reset_i && (m_off != 0);
  endfunction

  function automatic bit m_ready();
    return reset_i || !m_rv || (m_off == 1 && fe_cmd_yumi_i);
  endfunction

  function automatic logic [W-1:0] m_cmd();
    if (m_off == 1) return m_rcmd;
    if (m_off == 2 && m_q.size() > 0) return m_q[0];
    return '0;
  endfunction

  // Apply one cycle of inputs (after the falling edge); yumi only when offered.
  task automatic drive(input bit rst, input bit rv, input logic [W-1:0] rc,
                       input bit av, input logic [W-1:0] ac, input bit fl,
                       input bit ym);
    reset_i        = rst;
    redirect_v_i   = rv;
    redirect_cmd_i = rc;
    attaboy_v_i    = av;
    attaboy_cmd_i  = ac;
    flush_i        = fl;
    fe_cmd_yumi_i  = ym && !rst && (m_off != 0);
    #1;
  endtask

  // Advance one clock and update the model from the rules.
  task automatic tick();
    bit rst, rv, av, fl, ym, rdy, decide;
    logic [W-1:0] rc, ac, keep;
    rst = reset_i; rv = redirect_v_i; av = attaboy_v_i; fl = flush_i;
    ym = fe_cmd_yumi_i; rc = redirect_cmd_i; ac = attaboy_cmd_i;
    rdy = m_ready();
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_rv = 0; m_off = 0; m_drop = 0;
    end else begin
      decide = (m_off == 0) || ym;
      if (ym && m_off == 1) m_rv = 0;
      if (ym && m_off == 2) void'(m_q.pop_front());
      if (rv && rdy) begin m_rv = 1; m_rcmd = rc; end
      if (fl) begin
        if (m_off == 2 && !ym) begin
          keep = m_q[0]; m_q.delete(); m_q.push_back(keep);
        end else begin
          m_q.delete();
        end
      end else if (av) begin
        if (m_q.size() < N) m_q.push_back(ac);
        else if (m_drop < 255) m_drop++;
      end
      if (decide) m_off = m_rv ? 1 : ((m_q.size() != 0) ? 2 : 0);
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(0, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, '0, 0, '0, 0, 0); tick();
    drive(1, 0, '0, 0, '0, 0, 0); tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 32'hDEAD_0001, 1, 32'hDEAD_0002, 0, 0);
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL rst_v_during: got %b expected 0", fe_cmd_v_o); end
    checks++; if (redirect_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_during: got %b expected 1", redirect_ready_o); end
    tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL rst_v_after: got %b expected 0", fe_cmd_v_o); end
    checks++; if (drop_count_o !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", drop_count_o); end
    checks++; if (redirect_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", redirect_ready_o); end
    tick();
  endtask

  task automatic test_redirect_basic();
    logic [W-1:0] a;
    a = $urandom;
    do_reset();
    drive(0, 1, a, 0, '0, 0, 0);
    checks++; if (redirect_ready_o !== 1'b1) begin errors++; $display("FAIL rb_ready0: got %b expected 1", redirect_ready_o); end
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL rb_v0: got %b expected 0", fe_cmd_v_o); end
    tick();
    drive(0, 0, '0, 0, '0, 0, 1);
    checks++; if (fe_cmd_v_o !== 1'b1) begin errors++; $display("FAIL rb_v1: got %b expected 1", fe_cmd_v_o); end
    checks++; if (fe_cmd_o !== a) begin errors++; $display("FAIL rb_cmd1: got %h expected %h", fe_cmd_o, a); end
    checks++; if (redirect_ready_o !== 1'b1) begin errors++; $display("FAIL rb_ready1: got %b expected 1", redirect_ready_o); end
    tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL rb_v2: got %b expected 0", fe_cmd_v_o); end
    checks++; if (redirect_ready_o !== 1'b1) begin errors++; $display("FAIL rb_ready2: got %b expected 1", redirect_ready_o); end
    tick();
  endtask

  task automatic test_overflow();
    logic [W-1:0] t [6];
    for (int k = 0; k < 6; k++) t[k] = $urandom;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, '0, 1, t[k], 0, 0);
      if (k >= 1) begin
        checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== t[0]) begin errors++; $display("FAIL ov_hold%0d: got v=%b %h expected v=1 %h", k, fe_cmd_v_o, fe_cmd_o, t[0]); end
      end
      tick();
    end
    idle_cycle();
    checks++; if (drop_count_o !== 8'd2) begin errors++; $display("FAIL ov_drop: got %0d expected 2", drop_count_o); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, 0, '0, 0, 1);
      checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== t[k]) begin errors++; $display("FAIL ov_drain%0d: got v=%b %h expected v=1 %h", k, fe_cmd_v_o, fe_cmd_o, t[k]); end
      tick();
    end
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL ov_empty: got %b expected 0", fe_cmd_v_o); end
    tick();
  endtask

  task automatic test_no_preempt();
    logic [W-1:0] t0, t1, r;
    t0 = $urandom; t1 = $urandom; r = $urandom;
    do_reset();
    drive(0, 0, '0, 1, t0, 0, 0); tick();
    drive(0, 0, '0, 1, t1, 0, 0); tick();
    drive(0, 1, r, 0, '0, 0, 0);
    checks++; if (redirect_ready_o !== 1'b1) begin errors++; $display("FAIL np_ready: got %b expected 1", redirect_ready_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, '0, 0, '0, 0, k == 2);
      checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== t0) begin errors++; $display("FAIL np_hold%0d: got v=%b %h expected v=1 %h", k, fe_cmd_v_o, fe_cmd_o, t0); end
      checks++; if (redirect_ready_o !== 1'b0) begin errors++; $display("FAIL np_full%0d: got %b expected 0", k, redirect_ready_o); end
      tick();
    end
    drive(0, 0, '0, 0, '0, 0, 1);
    checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== r) begin errors++; $display("FAIL np_redir: got v=%b %h expected v=1 %h", fe_cmd_v_o, fe_cmd_o, r); end
    tick();
    drive(0, 0, '0, 0, '0, 0, 1);
    checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== t1) begin errors++; $display("FAIL np_t1: got v=%b %h expected v=1 %h", fe_cmd_v_o, fe_cmd_o, t1); end
    tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL np_idle: got %b expected 0", fe_cmd_v_o); end
    tick();
  endtask

  task automatic test_flush();
    logic [W-1:0] t [4];
    for (int k = 0; k < 4; k++) t[k] = $urandom;
    do_reset();
    for (int k = 0; k < 3; k++) begin drive(0, 0, '0, 1, t[k], 0, 0); tick(); end
    drive(0, 0, '0, 1, t[3], 1, 0);
    checks++; if (fe_cmd_o !== t[0]) begin errors++; $display("FAIL fl_pre: got %h expected %h", fe_cmd_o, t[0]); end
    tick();
    drive(0, 0, '0, 0, '0, 0, 1);
    checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== t[0]) begin errors++; $display("FAIL fl_keep: got v=%b %h expected v=1 %h", fe_cmd_v_o, fe_cmd_o, t[0]); end
    checks++; if (drop_count_o !== 8'd0) begin errors++; $display("FAIL fl_drop: got %0d expected 0", drop_count_o); end
    tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL fl_idle: got %b expected 0", fe_cmd_v_o); end
    tick();
  endtask

  task automatic test_redirect_backpressure();
    logic [W-1:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    do_reset();
    drive(0, 1, r1, 0, '0, 0, 0); tick();
    drive(0, 1, r2, 0, '0, 0, 0);
    checks++; if (redirect_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready0: got %b expected 0", redirect_ready_o); end
    checks++; if (fe_cmd_o !== r1) begin errors++; $display("FAIL bp_r1: got %h expected %h", fe_cmd_o, r1); end
    tick();
    drive(0, 1, r2, 0, '0, 0, 1);
    checks++; if (redirect_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", redirect_ready_o); end
    tick();
    drive(0, 0, '0, 0, '0, 0, 1);
    checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== r2) begin errors++; $display("FAIL bp_r2: got v=%b %h expected v=1 %h", fe_cmd_v_o, fe_cmd_o, r2); end
    tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", fe_cmd_v_o); end
    tick();
  endtask

  task automatic test_reset_mid_offer();
    logic [W-1:0] r;
    r = $urandom;
    do_reset();
    for (int k = 0; k < 11; k++) begin drive(0, 0, '0, 1, $urandom, 0, 0); tick(); end
    drive(0, 1, r, 0, '0, 0, 1); tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== r) begin errors++; $display("FAIL rm_r: got v=%b %h expected v=1 %h", fe_cmd_v_o, fe_cmd_o, r); end
    checks++; if (drop_count_o !== 8'd7) begin errors++; $display("FAIL rm_drop7: got %0d expected 7", drop_count_o); end
    tick();
    drive(1, 0, '0, 0, '0, 0, 0);
    checks++; if (fe_cmd_v_o !== 1'b0 || redirect_ready_o !== 1'b1) begin errors++; $display("FAIL rm_during: got v=%b rdy=%b expected v=0 rdy=1", fe_cmd_v_o, redirect_ready_o); end
    tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0 || drop_count_o !== 8'd0) begin errors++; $display("FAIL rm_after: got v=%b drop=%0d expected v=0 drop=0", fe_cmd_v_o, drop_count_o); end
    tick();
    idle_cycle();
    checks++; if (fe_cmd_v_o !== 1'b0) begin errors++; $display("FAIL rm_empty: got %b expected 0", fe_cmd_v_o); end
    tick();
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int k = 0; k < 264; k++) begin drive(0, 0, '0, 1, $urandom, 0, 0); tick(); end
    idle_cycle();
    checks++; if (drop_count_o !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d expected 255", drop_count_o); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0);
      checks++; if (fe_cmd_v_o !== m_v()) begin errors++; $display("FAIL rnd_v@%0d: got %b expected %b", i, fe_cmd_v_o, m_v()); end
      checks++; if (redirect_ready_o !== m_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", i, redirect_ready_o, m_ready()); end
      checks++; if (drop_count_o !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop@%0d: got %0d expected %0d", i, drop_count_o, m_drop); end
      if (m_v()) begin
        checks++; if (fe_cmd_o !== m_cmd()) begin errors++; $display("FAIL rnd_cmd@%0d: got %h expected %h", i, fe_cmd_o, m_cmd()); end
      end
      tick();
    end
  endtask

  initial begin
    m_rv = 0; m_off = 0; m_drop = 0; m_rcmd = '0;
    reset_i = 1'b1; redirect_v_i = 1'b0; attaboy_v_i = 1'b0; flush_i = 1'b0;
    fe_cmd_yumi_i = 1'b0; redirect_cmd_i = '0; attaboy_cmd_i = '0;
    @(negedge clk);
    test_reset();
    test_redirect_basic();
    test_overflow();
    test_no_preempt();
    test_flush();
    test_redirect_backpressure();
    test_reset_mid_offer();
    test_drop_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_fe_cmd_arbiter.md
BP_FE_CMD_ARBITER -- requirements
Module: bp_fe_cmd_arbiter

Interface
REQ-001 SHALL have parameter cmd_width_p, default 128, width of one FE command word (opaque to this block).
REQ-002 SHALL have parameter attaboy_els_p, default 4, attaboy queue depth; legal range 2..16, power of two.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port redirect_cmd_i  input  cmd_width_p  non-attaboy command (redirect, fill response, fence, wait, state reset).
REQ-006 SHALL have port redirect_v_i  input  1  redirect_cmd_i valid.
REQ-007 SHALL have port redirect_ready_o  output  1  redirect slot can accept this cycle (ready/valid).
REQ-008 SHALL have port attaboy_cmd_i  input  cmd_width_p  attaboy training command.
REQ-009 SHALL have port attaboy_v_i  input  1  attaboy valid; always accepted or dropped, never back-pressured.
REQ-010 SHALL have port flush_i  input  1  discard queued attaboys.
REQ-011 SHALL have port fe_cmd_o  output  cmd_width_p  command offered to FE.
REQ-012 SHALL have port fe_cmd_v_o  output  1  fe_cmd_o valid (valid-then-yumi).
REQ-013 SHALL have port fe_cmd_yumi_i  input  1  FE consumes fe_cmd_o this cycle; only asserted when fe_cmd_v_o=1.
REQ-014 SHALL have port drop_count_o  output  8  saturating count of attaboys discarded on overflow.

Function
REQ-015 SHALL hold one redirect entry (redirect_full_r) and an attaboy FIFO of attaboy_els_p entries with head/tail pointers wrapping modulo attaboy_els_p, plus an occupancy counter 0..attaboy_els_p.
REQ-016 SHALL implement states e_idle (fe_cmd_v_o=0), e_redir (fe_cmd_o = redirect entry), e_atta (fe_cmd_o = FIFO head); fe_cmd_v_o = (state != e_idle).
REQ-017 SHALL drive redirect_ready_o = ~redirect_full_r | (state==e_redir & fe_cmd_yumi_i).
REQ-018 SHALL capture redirect_cmd_i when redirect_v_i & redirect_ready_o; entry first offered next cycle (1-cycle latency).
REQ-019 SHALL enqueue attaboy_cmd_i when attaboy_v_i and (count<attaboy_els_p or same-cycle dequeue); entry first offerable next cycle.
REQ-020 SHALL, when attaboy_v_i, FIFO full and no same-cycle dequeue, discard the incoming attaboy and increment drop_count_o, saturating at 255.
REQ-021 SHALL hold fe_cmd_o and state stable while fe_cmd_v_o=1 and fe_cmd_yumi_i=0 (no preemption, even by a new redirect).
REQ-022 SHALL compute next state at decision points (state e_idle, or yumi this cycle) from post-update contents: redirect entry valid -> e_redir; else FIFO non-empty -> e_atta; else e_idle; redirect strictly has priority.
REQ-023 SHALL on yumi in e_redir clear redirect_full_r unless refilled same cycle; on yumi in e_atta pop head.
REQ-024 SHALL on flush_i empty the FIFO, except a head currently offered in e_atta without yumi, which is retained until consumed; then head is the sole entry.
REQ-025 SHALL give flush_i precedence over same-cycle attaboy enqueue; the discarded attaboy does not increment drop_count_o.
REQ-026 SHALL apply flush_i and yumi in the same cycle as: pop head, then flush leaves FIFO empty.
REQ-027 SHALL never emit X on fe_cmd_o when fe_cmd_v_o=1, and never reorder attaboys.

Reset
REQ-028 SHALL on reset_i=1 at a clock edge set state e_idle, redirect_full_r=0, FIFO count/pointers 0, drop_count_o=0, overriding all same-cycle inputs.
REQ-029 SHALL during reset drive fe_cmd_v_o=0, redirect_ready_o=1; reset mid-offer abandons the offered command with no yumi required.

Verification
REQ-030 Redirect A at cycle 0, FE yumi at cycle 1 -> fe_cmd_v_o=1, fe_cmd_o=A at cycle 1; e_idle at cycle 2; redirect_ready_o=1 throughout.
REQ-031 Attaboys T0..T5 on consecutive cycles, no yumi, depth 4 -> T0 offered from cycle 1; T4, T5 dropped; drop_count_o=2; then yumi drains T0..T3 in order.
REQ-032 T0 offered, redirect R arrives, yumi withheld 3 cycles -> fe_cmd_o stays T0; after yumi on T0, R offered next cycle ahead of queued T1.
REQ-033 Queue T0(offered),T1,T2, flush_i with attaboy T3 same cycle -> T0 retained, T1,T2,T3 gone, drop_count_o unchanged; after yumi -> e_idle.
REQ-034 Redirect held unconsumed, second redirect presented -> redirect_ready_o=0; yumi same cycle -> ready=1, second captured, offered next cycle.
REQ-035 Reset asserted while offering R with 3 attaboys queued and drop_count_o=7 -> next cycle fe_cmd_v_o=0, queue empty, drop_count_o=0.
